// File: rtl/secuenciador_pb20000_if.sv
// Control bundle between the biquad sequencer and the sampling logic / filter datapath.
interface secuenciador_pb20000_if;
  logic       start;
  logic       clr_ovr;
  logic [2:0] muxS;
  logic [1:0] muxC;
  logic [1:0] muxZ;
  logic       en1;
  logic       en2;
  logic       en3;
  logic       en4;
  logic       busy;
  logic       done;
  logic       overrun;

  modport master (
    input  start, clr_ovr,
    output muxS, muxC, muxZ, en1, en2, en3, en4, busy, done, overrun
  );

  modport slave (
    output start, clr_ovr,
    input  muxS, muxC, muxZ, en1, en2, en3, en4, busy, done, overrun
  );
endinterface

// File: rtl/secuenciador_pb20000.sv
// Sequencer for the direct-form-II low-pass biquad: one 6-step MAC schedule per sample strobe.
//   state | meaning
//   IDLE  | waiting for start
//   ACC1  | F <= U - a1*F1
//   ACC2  | F <= F - a2*F2
//   OUT0  | Y <= b0*F
//   OUT1  | Y <= Y + b1*F1
//   OUT2  | Y <= Y + b0*F2
//   SHIFT | F2 <= F1, F1 <= F
//   DONE  | Y valid, may restart immediately
module secuenciador_pb20000 (
  input logic                    clk,
  input logic                    reset,
  secuenciador_pb20000_if.master bus
);
  localparam logic [2:0] SEL_UK   = 3'd0;
  localparam logic [2:0] SEL_FK   = 3'd1;
  localparam logic [2:0] SEL_YK   = 3'd2;
  localparam logic [2:0] SEL_ZERO = 3'd3;
  localparam logic [1:0] C_NA1    = 2'd0;
  localparam logic [1:0] C_NA2    = 2'd1;
  localparam logic [1:0] C_B0     = 2'd2;
  localparam logic [1:0] C_B1     = 2'd3;
  localparam logic [1:0] Z_FK     = 2'd0;
  localparam logic [1:0] Z_FK1    = 2'd1;
  localparam logic [1:0] Z_FK2    = 2'd2;

  typedef enum logic [2:0] {
    IDLE, ACC1, ACC2, OUT0, OUT1, OUT2, SHIFT, DONE
  } state_t;

  state_t state_q, state_d;
  logic   overrun_q, overrun_d;
  logic   busy_w;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy_w = (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = ACC1;
      ACC1:    state_d = ACC2;
      ACC2:    state_d = OUT0;
      OUT0:    state_d = OUT1;
      OUT1:    state_d = OUT2;
      OUT2:    state_d = SHIFT;
      SHIFT:   state_d = DONE;
      DONE:    state_d = bus.start ? ACC1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A strobe during the schedule is dropped; setting outranks a same-cycle clear.
  always_comb begin
    overrun_d = overrun_q;
    if (bus.start && busy_w)
      overrun_d = 1'b1;
    else if (bus.clr_ovr)
      overrun_d = 1'b0;
  end

  logic [2:0] mux_s;
  logic [1:0] mux_c;
  logic [1:0] mux_z;
  logic [3:0] en;

  always_comb begin
    mux_s = SEL_ZERO;
    mux_c = C_NA1;
    mux_z = Z_FK;
    en    = 4'b0000;
    unique case (state_q)
      ACC1:  begin mux_s = SEL_UK;   mux_c = C_NA1; mux_z = Z_FK1; en = 4'b0010; end
      ACC2:  begin mux_s = SEL_FK;   mux_c = C_NA2; mux_z = Z_FK2; en = 4'b0010; end
      OUT0:  begin mux_s = SEL_ZERO; mux_c = C_B0;  mux_z = Z_FK;  en = 4'b0001; end
      OUT1:  begin mux_s = SEL_YK;   mux_c = C_B1;  mux_z = Z_FK1; en = 4'b0001; end
      OUT2:  begin mux_s = SEL_YK;   mux_c = C_B0;  mux_z = Z_FK2; en = 4'b0001; end
      SHIFT: en = 4'b1100;
      default: ;
    endcase
  end

  assign bus.muxS    = mux_s;
  assign bus.muxC    = mux_c;
  assign bus.muxZ    = mux_z;
  assign bus.en1     = en[0];
  assign bus.en2     = en[1];
  assign bus.en3     = en[2];
  assign bus.en4     = en[3];
  assign bus.busy    = busy_w;
  assign bus.done    = (state_q == DONE);
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_secuenciador_pb20000.sv
// Scoreboard bench for the biquad sequencer, with a small behavioural filter datapath.
module tb_secuenciador_pb20000;
  logic clk;
  logic reset;
  secuenciador_pb20000_if bus ();

  secuenciador_pb20000 dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected output vector: {muxS, muxC, muxZ, en1, en2, en3, en4, busy, done}
  logic [12:0] sched_q[$];
  int          yk_q[$];
  logic        ovr_exp = 1'b0;
  logic        busy_exp = 1'b0;

  function automatic logic [12:0] step_vec(int s);
    case (s)
      1:       return {3'd0, 2'd0, 2'd1, 4'b0100, 1'b1, 1'b0};
      2:       return {3'd1, 2'd1, 2'd2, 4'b0100, 1'b1, 1'b0};
      3:       return {3'd3, 2'd2, 2'd0, 4'b1000, 1'b1, 1'b0};
      4:       return {3'd2, 2'd3, 2'd1, 4'b1000, 1'b1, 1'b0};
      5:       return {3'd2, 2'd2, 2'd2, 4'b1000, 1'b1, 1'b0};
      6:       return {3'd3, 2'd0, 2'd0, 4'b0011, 1'b1, 1'b0};
      7:       return {3'd3, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b1};
      default: return {3'd3, 2'd0, 2'd0, 4'b0000, 1'b0, 1'b0};
    endcase
  endfunction

  function automatic logic [12:0] dut_vec();
    return {bus.muxS, bus.muxC, bus.muxZ, bus.en1, bus.en2, bus.en3, bus.en4, bus.busy, bus.done};
  endfunction

  // Behavioural filter datapath driven by the sequencer outputs.
  int signed uk, yk, fk, fk1, fk2;
  int signed dato1, dato2, dato3, resultado;
  localparam int signed NA1 = 0, NA2 = 0, B0 = 1, B1 = 2;

  always_comb begin
    dato1 = 0;
    dato2 = 0;
    dato3 = 0;
    case (bus.muxS)
      3'd0: dato1 = uk;
      3'd1: dato1 = fk;
      3'd2: dato1 = yk;
      default: dato1 = 0;
    endcase
    case (bus.muxC)
      2'd0: dato2 = NA1;
      2'd1: dato2 = NA2;
      2'd2: dato2 = B0;
      default: dato2 = B1;
    endcase
    case (bus.muxZ)
      2'd0: dato3 = fk;
      2'd1: dato3 = fk1;
      default: dato3 = fk2;
    endcase
    resultado = dato1 + dato2 * dato3;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      yk <= 0; fk <= 0; fk1 <= 0; fk2 <= 0;
    end else begin
      if (bus.en1) yk <= resultado;
      if (bus.en2) fk <= resultado;
      if (bus.en3) fk1 <= fk;
      if (bus.en4) fk2 <= fk1;
    end
  end

  task automatic push_sched();
    for (int s = 1; s <= 7; s++) sched_q.push_back(step_vec(s));
  endtask

  // Advance one cycle, then compare outputs against the scoreboard head.
  task automatic step(string tag);
    logic        nxt_ovr;
    logic [12:0] e;
    logic [12:0] a;
    nxt_ovr = (bus.start && busy_exp) ? 1'b1 : (bus.clr_ovr ? 1'b0 : ovr_exp);
    @(posedge clk);
    #1;
    ovr_exp  = nxt_ovr;
    e        = (sched_q.size() > 0) ? sched_q.pop_front() : step_vec(0);
    busy_exp = e[1];
    a        = dut_vec();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s outputs: got %b expected %b at %0t", tag, a, e, $time);
    end
    checks++;
    if (bus.overrun !== ovr_exp) begin
      failures++;
      $display("FAIL %s overrun: got %b expected %b at %0t", tag, bus.overrun, ovr_exp, $time);
    end
    if (e[0] && yk_q.size() > 0) begin
      int ye;
      ye = yk_q.pop_front();
      checks++;
      if (yk !== ye) begin
        failures++;
        $display("FAIL %s yk: got %0d expected %0d", tag, yk, ye);
      end
    end
    bus.start   = 1'b0;
    bus.clr_ovr = 1'b0;
  endtask

  task automatic apply_reset_async();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== step_vec(0) || bus.overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got %b ovr %b expected %b ovr 0", dut_vec(), bus.overrun, step_vec(0));
    end
    sched_q.delete();
    ovr_exp  = 1'b0;
    busy_exp = 1'b0;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset_async();
    for (int i = 0; i < 10; i++) step("reset_idle");
  endtask

  task automatic test_single();
    bus.start = 1'b1;
    push_sched();
    for (int i = 0; i < 9; i++) step("single");
  endtask

  task automatic test_back_to_back();
    bus.start = 1'b1;
    push_sched();
    for (int i = 0; i < 7; i++) step("b2b_first");
    bus.start = 1'b1;
    push_sched();
    for (int i = 0; i < 9; i++) step("b2b_second");
  endtask

  task automatic test_overrun();
    bus.start = 1'b1;
    push_sched();
    for (int i = 0; i < 3; i++) step("ovr_pre");
    bus.start = 1'b1;
    for (int i = 0; i < 7; i++) step("ovr_set");
    bus.clr_ovr = 1'b1;
    step("ovr_clr");
    bus.start = 1'b1;
    push_sched();
    step("ovr_both_pre");
    bus.start   = 1'b1;
    bus.clr_ovr = 1'b1;
    for (int i = 0; i < 8; i++) step("ovr_both");
    bus.clr_ovr = 1'b1;
    step("ovr_final_clr");
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1;
    push_sched();
    for (int i = 0; i < 3; i++) step("mid_pre");
    apply_reset_async();
    for (int i = 0; i < 3; i++) step("mid_idle");
    bus.start = 1'b1;
    push_sched();
    for (int i = 0; i < 8; i++) step("mid_clean");
  endtask

  task automatic test_filter();
    int u_seq[3] = '{5, 0, 0};
    apply_reset_async();
    yk_q.push_back(5);
    yk_q.push_back(10);
    yk_q.push_back(5);
    for (int k = 0; k < 3; k++) begin
      uk = u_seq[k];
      bus.start = 1'b1;
      push_sched();
      for (int i = 0; i < 7; i++) step("filter");
    end
    checks++;
    if (yk_q.size() != 0) begin
      failures++;
      $display("FAIL filter_done_count: got %0d pending expected 0", yk_q.size());
    end
  endtask

  initial begin
    reset       = 1'b0;
    bus.start   = 1'b0;
    bus.clr_ovr = 1'b0;
    uk          = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_filter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/secuenciador_pb20000.md
Name: secuenciador_pb20000

Overview:
- Control FSM for the 2nd-order low-pass filter datapath: the mux bank, the Y(K), F(K), F(K-1) and F(K-2) registers, and the arithmetic unit computing resultado = dato1 + dato2*dato3.
- On each sample strobe it issues the fixed 6-step direct-form-II biquad schedule, driving muxS/muxC/muxZ and en1..en4 of the filter top.
- Reports busy/done to the sampling logic and flags sample overruns.
- Sits between the ADC sample-tick generator and the filter datapath.

Parameters:
- SEL_UK, 3'd0, muxS code selecting U(K) as dato1
- SEL_FK, 3'd1, muxS code selecting F(K) as dato1
- SEL_YK, 3'd2, muxS code selecting Y(K) as dato1
- SEL_ZERO, 3'd3, muxS code selecting constant 0 as dato1
- C_NA1, 2'd0, muxC code for coefficient -a1
- C_NA2, 2'd1, muxC code for -a2
- C_B0, 2'd2, muxC code for b0 (also used as b2; low-pass section has b2 = b0)
- C_B1, 2'd3, muxC code for b1
- Z_FK, 2'd0, muxZ code for F(K)
- Z_FK1, 2'd1, muxZ code for F(K-1)
- Z_FK2, 2'd2, muxZ code for F(K-2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  sample strobe; new U(K) is valid while start is high and for the following 6 cycles
- clr_ovr  in  1  synchronous clear of overrun
- muxS  out  3  dato1 select to filter
- muxC  out  2  coefficient select to filter
- muxZ  out  2  data-operand select to filter
- en1  out  1  Y(K) load enable
- en2  out  1  F(K) load enable
- en3  out  1  F(K-1) load enable
- en4  out  1  F(K-2) load enable
- busy  out  1  high while the schedule runs
- done  out  1  1-cycle pulse; Y(K) valid
- overrun  out  1  sticky: start arrived while busy

Behaviour:
- FSM states: IDLE, ACC1, ACC2, OUT0, OUT1, OUT2, SHIFT, DONE.
- All outputs are a Moore decode of registered state and flags only; no start-to-output combinational path.
- Reset (async, any time, including mid-sequence) forces:
  - state = IDLE, overrun = 0
  - all enables = 0, busy = 0, done = 0
  - muxS = SEL_ZERO, muxC = C_NA1, muxZ = Z_FK
- Cycle 0 is the cycle in which start = 1 is sampled in IDLE or DONE. Schedule per cycle:
  - cycle 1, ACC1: muxS=SEL_UK, muxC=C_NA1, muxZ=Z_FK1, en2=1 (F <= U - a1*F1)
  - cycle 2, ACC2: muxS=SEL_FK, muxC=C_NA2, muxZ=Z_FK2, en2=1 (F <= F - a2*F2)
  - cycle 3, OUT0: muxS=SEL_ZERO, muxC=C_B0, muxZ=Z_FK, en1=1
  - cycle 4, OUT1: muxS=SEL_YK, muxC=C_B1, muxZ=Z_FK1, en1=1
  - cycle 5, OUT2: muxS=SEL_YK, muxC=C_B0, muxZ=Z_FK2, en1=1
  - cycle 6, SHIFT: en3=1 and en4=1 in the same cycle (F2 <= F1, F1 <= F); mux outputs hold their idle values
  - cycle 7, DONE: done=1, busy=0, all enables 0
- Transitions:
  - IDLE -> ACC1 when start = 1.
  - DONE -> ACC1 when start = 1 (back-to-back, 7-cycle sample period minimum); otherwise DONE -> IDLE.
- busy = 1 in cycles 1..6 only.
- Enables outside the listed cycles are 0.
- Exactly one of en1/en2 per cycle in cycles 1..5.
- Overrun handling:
  - start = 1 while busy: request ignored, schedule continues unchanged, overrun set at the next edge.
  - clr_ovr clears overrun; if set and clear occur in the same cycle, set wins.
- start held high continuously: treated as a new request each time the FSM is in IDLE or DONE. Cycles spent busy set overrun.
- Latency start -> done = 7 cycles; Y(K) register valid from cycle 6 edge onward.

Test Plan:
- Reset asserted asynchronously between edges -> all outputs at reset values immediately; after release with start=0 for 10 cycles, FSM stays IDLE, no enables.
- Single start pulse in cycle 0 -> cycles 1..7 show exactly the muxS/muxC/muxZ/en codes listed above (e.g. cycle 4: 2/3/1, en1=1); done=1 only in cycle 7; overrun=0.
- start pulses in cycle 0 and cycle 7 -> second schedule begins cycle 8, done pulses in cycles 7 and 14, overrun stays 0.
- start pulse in cycle 3 -> schedule unchanged, overrun=1 from cycle 4; clr_ovr in cycle 10 -> overrun=0 at cycle 11. Start and clr_ovr together in a busy cycle -> overrun=1.
- Reset in cycle 3 (OUT0) -> enables drop at once; after release, FSM IDLE; next start produces a full clean schedule.
- Integrated with the filter top, coefficients -a1=0, -a2=0, b0=1, b1=2, F(K-1)=F(K-2)=0, U=5 -> Y(K)=5 at done; next sample U=0 -> Y=10; next U=0 -> Y=5.
